// File: rtl/uart_pkg.sv
// Shared constants for the UART receive controller: data width, parameter
// defaults and the legacy numeric state encoding exposed on state_o.
package uart_pkg;

  localparam int unsigned DATA_W                = 8;
  localparam int unsigned DEF_DIV_W             = 16;
  localparam int unsigned DEF_FIFO_DEPTH        = 8;
  localparam int unsigned DEF_ARM_TICKS         = 2;
  localparam int unsigned DEF_RECOVER_TICKS     = 16;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_ACTIVE  = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes, with exact
// level and a one-cycle overrun pulse when a push is dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);
  assign overrun   = push && full && !w_do_pop;
  assign level     = r_level;
  assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 16x tick generation, receiver arm/recover control,
// byte capture into the RX FIFO and sticky error status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W         = DEF_DIV_W,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int unsigned ARM_TICKS     = DEF_ARM_TICKS,
  parameter int unsigned RECOVER_TICKS = DEF_RECOVER_TICKS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          rx_tick,
  output logic                          rx_en,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_err,
  input  logic                          rx_perr,
  input  logic [DATA_W-1:0]             rx_data,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          clr_status,
  output logic                          ovr_err,
  output logic                          frm_err,
  output logic                          par_err,
  output logic [2:0]                    state_o
);

  localparam int unsigned MAX_TICKS = (ARM_TICKS > RECOVER_TICKS) ? ARM_TICKS : RECOVER_TICKS;
  localparam int unsigned TCNT_W    = $clog2(MAX_TICKS) + 1;
  localparam logic [TCNT_W-1:0] ARM_LAST = TCNT_W'(ARM_TICKS - 1);
  localparam logic [TCNT_W-1:0] REC_LAST = TCNT_W'(RECOVER_TICKS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [TCNT_W-1:0] r_tcnt;
  logic              w_tick;
  logic              r_done_q;
  logic              r_err_q;
  logic              r_perr_q;
  logic              w_done_ev;
  logic              w_err_ev;
  logic              w_perr_ev;
  logic              w_push;
  logic              w_ovr_pulse;
  logic              w_empty;
  logic              w_full;
  logic              r_ovr;
  logic              r_frm;
  logic              r_par;

  assign w_tick    = (r_state != ST_OFF) && (r_div_cnt == baud_div);
  assign w_done_ev = rx_done && !r_done_q;
  assign w_err_ev  = rx_err  && !r_err_q;
  assign w_perr_ev = rx_perr && !r_perr_q;

  // Counter increments freely past a lowered baud_div and wraps at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (r_state == ST_OFF || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
      r_err_q  <= 1'b0;
      r_perr_q <= 1'b0;
    end else begin
      r_done_q <= rx_done;
      r_err_q  <= rx_err;
      r_perr_q <= rx_perr;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_OFF:     if (cfg_en) w_next = ST_ARM;
      ST_ARM:     if (w_tick && r_tcnt == ARM_LAST) w_next = ST_IDLE;
      ST_IDLE:    if (rx_busy) w_next = ST_ACTIVE;
      ST_ACTIVE: begin
        if (w_err_ev || w_perr_ev) w_next = ST_RECOVER;
        else if (w_done_ev)        w_next = ST_IDLE;
      end
      ST_RECOVER: if (w_tick && r_tcnt == REC_LAST) w_next = ST_ARM;
      default:    w_next = ST_OFF;
    endcase
    if (!cfg_en) w_next = ST_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_tcnt <= '0;
      end else if (w_tick && (r_state == ST_ARM || r_state == ST_RECOVER)) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  // Push is decided from the current state, so a byte completing as cfg_en falls still lands.
  assign w_push = w_done_ev &&
                  ((r_state == ST_IDLE) ||
                   (r_state == ST_ACTIVE && !w_err_ev && !w_perr_ev));

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (rx_data),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level),
    .overrun   (w_ovr_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr <= 1'b0;
      r_frm <= 1'b0;
      r_par <= 1'b0;
    end else begin
      r_ovr <= (r_ovr && !clr_status) || w_ovr_pulse;
      r_frm <= (r_frm && !clr_status) || (r_state == ST_ACTIVE && w_err_ev);
      r_par <= (r_par && !clr_status) || (r_state == ST_ACTIVE && w_perr_ev);
    end
  end

  assign rx_tick  = w_tick;
  assign rx_en    = (r_state == ST_ARM) || (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
  assign rd_valid = !w_empty;
  assign ovr_err  = r_ovr;
  assign frm_err  = r_frm;
  assign par_err  = r_par;
  assign state_o  = r_state;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: the bench plays the receiver and the
// APB reader, predicting FIFO contents and sticky flags with a queue model.
module tb_uart_rx_ctrl;

  localparam int DEPTH    = 8;
  localparam int ARM_T    = 2;
  localparam int REC_T    = 16;
  localparam logic [2:0] S_OFF = 3'd0, S_ARM = 3'd1, S_IDLE = 3'd2,
                         S_ACTIVE = 3'd3, S_RECOVER = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b0;
  logic [15:0] baud_div = '0;
  logic        rx_tick, rx_en;
  logic        rx_busy = 1'b0, rx_done = 1'b0, rx_err = 1'b0, rx_perr = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic        clr_status = 1'b0;
  logic        ovr_err, frm_err, par_err;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  bit         m_ovr, m_frm, m_par;
  bit         popped;
  logic [7:0] pop_exp, pop_act;

  uart_rx_ctrl #(
    .DIV_W         (16),
    .FIFO_DEPTH    (DEPTH),
    .ARM_TICKS     (ARM_T),
    .RECOVER_TICKS (REC_T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .baud_div   (baud_div),
    .rx_tick    (rx_tick),
    .rx_en      (rx_en),
    .rx_busy    (rx_busy),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .rx_perr    (rx_perr),
    .rx_data    (rx_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .fifo_level (fifo_level),
    .clr_status (clr_status),
    .ovr_err    (ovr_err),
    .frm_err    (frm_err),
    .par_err    (par_err),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_wait();
    int n = 0;
    do begin
      step();
      n++;
    end while (!rx_tick && n < 500);
    if (!rx_tick) begin
      total++; bad++;
      $display("FAIL tick_timeout got=%0b want=1", rx_tick);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (state_o !== s && n < 4000) begin
      step();
      n++;
    end
    if (state_o !== s) begin
      total++; bad++;
      $display("FAIL %s_timeout got=%0d want=%0d", nm, state_o, s);
    end
  endtask

  // kind: 0 done, 1 framing err, 2 parity err, 3 both errors.
  task automatic do_frame(input logic [7:0] d, input int kind, input bit clr, input bit pop);
    wait_state(S_IDLE, "frame_idle");
    rx_busy = 1'b1;
    step();
    repeat ($urandom_range(0, 2)) tick_wait();
    rx_data    = d;
    rx_busy    = 1'b0;
    rx_done    = (kind == 0);
    rx_err     = (kind == 1 || kind == 3);
    rx_perr    = (kind >= 2);
    clr_status = clr;
    rd_ready   = pop;
    popped  = 1'b0;
    pop_act = rd_data;
    if (pop && model_q.size() > 0) begin
      pop_exp = model_q.pop_front();
      popped  = 1'b1;
    end
    if (clr) begin
      m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
    end
    if (kind == 0) begin
      if (model_q.size() == DEPTH) m_ovr = 1'b1;
      else model_q.push_back(d);
    end else begin
      if (kind != 2) m_frm = 1'b1;
      if (kind >= 2) m_par = 1'b1;
    end
    step();
    clr_status = 1'b0;
    rd_ready   = 1'b0;
  endtask

  task automatic drop_lines();
    rx_done = 1'b0; rx_err = 1'b0; rx_perr = 1'b0;
  endtask

  task automatic finish_frame();
    repeat (int'(baud_div)) step();
    drop_lines();
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    m_ovr = 1'b0; m_frm = 1'b0; m_par = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_tick, rx_en, rd_valid, ovr_err, frm_err, par_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {rx_tick, rx_en, rd_valid, ovr_err, frm_err, par_err});
    end
    total++;
    if (fifo_level !== 4'd0 || rd_data !== 8'h00) begin
      bad++; $display("FAIL reset_fifo got=%0d/%h want=0/00", fifo_level, rd_data);
    end
    total++;
    if (state_o !== S_OFF) begin
      bad++; $display("FAIL reset_state got=%0d want=%0d", state_o, S_OFF);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_divider();
    int n;
    int d;
    baud_div = 16'd3;
    cfg_en   = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rx_tick && n < 100);
    total++;
    if (n != 4) begin
      bad++; $display("FAIL div_first got=%0d want=4", n);
    end
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? 3 : (k == 1) ? 0 : int'($urandom_range(0, 6));
      step();
      baud_div = 16'(d);
      tick_wait();
      for (int j = 0; j < 2; j++) begin
        n = 0;
        do begin step(); n++; end while (!rx_tick && n < 100);
        total++;
        if (n != d + 1) begin
          bad++; $display("FAIL div_period div=%0d got=%0d want=%0d", d, n, d + 1);
        end
      end
    end
    cfg_en = 1'b0;
    step();
    total++;
    if (state_o !== S_OFF || rx_en !== 1'b0) begin
      bad++; $display("FAIL div_off got=%0d/%b want=0/0", state_o, rx_en);
    end
    n = 0;
    for (int j = 0; j < 12; j++) begin
      if (rx_tick) n++;
      step();
    end
    total++;
    if (n != 0) begin
      bad++; $display("FAIL div_off_tick got=%0d want=0", n);
    end
    baud_div = 16'd1;
    cfg_en = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rx_tick && n < 100);
    total++;
    if (n != 2) begin
      bad++; $display("FAIL div_cleared got=%0d want=2", n);
    end
  endtask

  task automatic test_normal_frame();
    int ticks = 0;
    int n = 0;
    cfg_en = 1'b0;
    step();
    cfg_en = 1'b1;
    while (state_o !== S_IDLE && n < 200) begin
      if (state_o === S_ARM && rx_tick) ticks++;
      step();
      n++;
    end
    total++;
    if (ticks != ARM_T) begin
      bad++; $display("FAIL arm_ticks got=%0d want=%0d", ticks, ARM_T);
    end
    do_frame(8'hA5, 0, 1'b0, 1'b0);
    finish_frame();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_level !== 4'd1) begin
      bad++;
      $display("FAIL frame_capture got=%b/%h/%0d want=1/a5/1", rd_valid, rd_data, fifo_level);
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    void'(model_q.pop_front());
    total++;
    if (rd_valid !== 1'b0) begin
      bad++; $display("FAIL frame_pop got=%b want=0", rd_valid);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) begin
      do_frame(8'(i), 0, 1'b0, 1'b0);
      finish_frame();
    end
    total++;
    if (fifo_level !== 4'd8 || ovr_err !== 1'b1 || rd_data !== 8'h01) begin
      bad++;
      $display("FAIL ovr_full got=%0d/%b/%h want=8/1/01", fifo_level, ovr_err, rd_data);
    end
    pulse_clr();
    total++;
    if (ovr_err !== 1'b0) begin
      bad++; $display("FAIL ovr_clear got=%b want=0", ovr_err);
    end
    do_frame(8'h0A, 0, 1'b0, 1'b1);
    finish_frame();
    total++;
    if (pop_act !== 8'h01 || !popped) begin
      bad++; $display("FAIL ovr_head got=%h want=01", pop_act);
    end
    total++;
    if (fifo_level !== 4'd8 || ovr_err !== 1'b0) begin
      bad++; $display("FAIL ovr_pushpop got=%0d/%b want=8/0", fifo_level, ovr_err);
    end
    while (model_q.size() > 0) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
        bad++; $display("FAIL ovr_drain got=%b/%h want=1/%h", rd_valid, rd_data, model_q[0]);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      void'(model_q.pop_front());
    end
    total++;
    if (rd_valid !== 1'b0 || fifo_level !== 4'd0) begin
      bad++; $display("FAIL ovr_empty got=%b/%0d want=0/0", rd_valid, fifo_level);
    end
  endtask

  task automatic test_framing();
    int rt = 0, at = 0, cyc = 0;
    bit en_seen = 1'b0;
    do_frame(8'h55, 1, 1'b0, 1'b0);
    total++;
    if (frm_err !== 1'b1 || state_o !== S_RECOVER) begin
      bad++; $display("FAIL frm_set got=%b/%0d want=1/%0d", frm_err, state_o, S_RECOVER);
    end
    while (state_o !== S_IDLE && cyc < 2000) begin
      if (cyc == int'(baud_div)) drop_lines();
      if (rx_tick && state_o === S_RECOVER) rt++;
      if (rx_tick && state_o === S_ARM) at++;
      if (state_o === S_RECOVER && rx_en !== 1'b0) en_seen = 1'b1;
      step();
      cyc++;
    end
    total++;
    if (rt != REC_T || at != ARM_T || en_seen) begin
      bad++;
      $display("FAIL frm_recover got=%0d/%0d/%b want=%0d/%0d/0", rt, at, en_seen, REC_T, ARM_T);
    end
    pulse_clr();
    total++;
    if (frm_err !== 1'b0) begin
      bad++; $display("FAIL frm_clear got=%b want=0", frm_err);
    end
    do_frame(8'h66, 1, 1'b1, 1'b0);
    total++;
    if (frm_err !== 1'b1) begin
      bad++; $display("FAIL frm_set_wins got=%b want=1", frm_err);
    end
    finish_frame();
  endtask

  task automatic test_parity();
    int lvl;
    lvl = model_q.size();
    do_frame(8'h77, 2, 1'b0, 1'b0);
    total++;
    if (par_err !== 1'b1 || state_o !== S_RECOVER || fifo_level !== 4'(lvl)) begin
      bad++;
      $display("FAIL par_set got=%b/%0d/%0d want=1/%0d/%0d", par_err, state_o, fifo_level, S_RECOVER, lvl);
    end
    finish_frame();
  endtask

  task automatic test_random();
    int kind, r;
    bit clr, pop;
    for (int i = 0; i < 24; i++) begin
      r    = int'($urandom_range(0, 9));
      kind = (r < 7) ? 0 : r - 6;
      clr  = ($urandom_range(0, 5) == 0);
      pop  = ($urandom_range(0, 1) == 1);
      do_frame(8'($urandom), kind, clr, pop);
      finish_frame();
      if (popped) begin
        total++;
        if (pop_act !== pop_exp) begin
          bad++; $display("FAIL rnd_pop got=%h want=%h", pop_act, pop_exp);
        end
      end
      if ($urandom_range(0, 2) == 0 && model_q.size() > 0) begin
        total++;
        if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
          bad++; $display("FAIL rnd_head got=%b/%h want=1/%h", rd_valid, rd_data, model_q[0]);
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        void'(model_q.pop_front());
      end
    end
    total++;
    if (fifo_level !== 4'(model_q.size())) begin
      bad++; $display("FAIL rnd_level got=%0d want=%0d", fifo_level, model_q.size());
    end
    total++;
    if ({ovr_err, frm_err, par_err} !== {m_ovr, m_frm, m_par}) begin
      bad++;
      $display("FAIL rnd_flags got=%b want=%b", {ovr_err, frm_err, par_err}, {m_ovr, m_frm, m_par});
    end
  endtask

  task automatic test_control();
    while (model_q.size() > 0) begin
      total++;
      if (rd_data !== model_q[0]) begin
        bad++; $display("FAIL ctl_drain got=%h want=%h", rd_data, model_q[0]);
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      void'(model_q.pop_front());
    end
    wait_state(S_IDLE, "ctl_idle");
    rx_busy = 1'b1;
    step();
    rx_busy = 1'b0;
    rx_data = 8'h3C;
    rx_done = 1'b1;
    cfg_en  = 1'b0;
    step();
    total++;
    if (state_o !== S_OFF || rx_en !== 1'b0) begin
      bad++; $display("FAIL ctl_off got=%0d/%b want=0/0", state_o, rx_en);
    end
    finish_frame();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || fifo_level !== 4'd1) begin
      bad++;
      $display("FAIL ctl_kept got=%b/%h/%0d want=1/3c/1", rd_valid, rd_data, fifo_level);
    end
    cfg_en = 1'b1;
    wait_state(S_IDLE, "ctl_idle2");
    rx_busy = 1'b1;
    step();
    rx_data = 8'hEE;
    rx_done = 1'b1;
    rst_n   = 1'b0;
    #1;
    total++;
    if ({rx_tick, rx_en, rd_valid, ovr_err, frm_err, par_err} !== 6'b0 ||
        fifo_level !== 4'd0 || state_o !== S_OFF) begin
      bad++;
      $display("FAIL ctl_async_reset got=%b/%0d/%0d want=000000/0/0",
               {rx_tick, rx_en, rd_valid, ovr_err, frm_err, par_err}, fifo_level, state_o);
    end
    rx_busy = 1'b0;
    drop_lines();
    step();
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (fifo_level !== 4'd0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL ctl_no_push got=%0d/%b want=0/0", fifo_level, rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_normal_frame();
    test_overrun();
    test_framing();
    test_parity();
    test_random();
    test_control();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
